// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: write-enable encoding,
// port identifier type and the number of requesting ports.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_WORD = 2'b01,
    WE_HALF = 2'b10,
    WE_BYTE = 2'b11
  } mem_we_e;

  typedef logic port_id_t;

  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port
// data memory. The slave modport is the arbiter's view; master is the
// view of the surrounding requesters and memory.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [NUM_PORTS-1:0]  req_i;
  logic [1:0]            we0_i;
  logic [1:0]            we1_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic [NUM_PORTS-1:0]  gnt_o;
  logic [NUM_PORTS-1:0]  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_a_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;

  modport slave (
    input  req_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rd_i,
    output gnt_o, rvalid_o, rdata_o, mem_we_o, mem_a_o, mem_wd_o
  );

  modport master (
    output req_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rd_i,
    input  gnt_o, rvalid_o, rdata_o, mem_we_o, mem_a_o, mem_wd_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and on a conflict the port that was not granted last wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic [1:0] gnt
);

  // One-hot pick from the request pair and the previous winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port
// data memory. Stage A grants and captures the winning request, stage B
// drives the memory for one cycle, and the response register returns the
// completion two cycles after the grant.
// Optional build macro: DMEM_ARB_PERF_EN adds saturating grant/conflict
// counters on three extra output ports.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DMEM_ARB_PERF_EN
  output logic [CNT_WIDTH-1:0] gnt_cnt0_o,
  output logic [CNT_WIDTH-1:0] gnt_cnt1_o,
  output logic [CNT_WIDTH-1:0] conflict_cnt_o,
`endif
  dmem_arbiter_if.slave        bus
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  port_id_t              last_q;
  logic [1:0]            gnt_pick;
  logic                  valid_b;
  mem_we_e               we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wd_b;
  port_id_t              id_b;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  rr_pick2 u_pick (
    .req  (bus.req_i),
    .last (last_q),
    .gnt  (gnt_pick)
  );

  // Grants are suppressed while reset is held so nothing is accepted then
  assign bus.gnt_o = rst_n ? gnt_pick : 2'b00;

  // Remember the most recent winner; reset favours port 0 on first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= 1'b1;
    else if (|gnt_pick)
      last_q <= gnt_pick[1];
  end

  // Stage A -> B: capture the winner's request; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_b <= 1'b0;
      we_b    <= WE_NONE;
      addr_b  <= '0;
      wd_b    <= '0;
      id_b    <= 1'b0;
    end else begin
      valid_b <= |gnt_pick;
      if (gnt_pick[1]) begin
        we_b   <= mem_we_e'(bus.we1_i);
        addr_b <= bus.addr1_i;
        wd_b   <= bus.wdata1_i;
        id_b   <= 1'b1;
      end else if (gnt_pick[0]) begin
        we_b   <= mem_we_e'(bus.we0_i);
        addr_b <= bus.addr0_i;
        wd_b   <= bus.wdata0_i;
        id_b   <= 1'b0;
      end
    end
  end

  // Memory is only ever written while a captured transaction is valid
  assign bus.mem_we_o = valid_b ? we_b : WE_NONE;
  assign bus.mem_a_o  = addr_b;
  assign bus.mem_wd_o = wd_b;

  // Stage B -> response: route completion to its port, zero data on writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= valid_b ? (id_b ? 2'b10 : 2'b01) : 2'b00;
      rdata_q  <= (valid_b && we_b == WE_NONE) ? bus.mem_rd_i : '0;
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

`ifdef DMEM_ARB_PERF_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating event counters for grants per port and request conflicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_o     <= '0;
      gnt_cnt1_o     <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (gnt_pick[0])          gnt_cnt0_o     <= sat_inc(gnt_cnt0_o);
      if (gnt_pick[1])          gnt_cnt1_o     <= sat_inc(gnt_cnt1_o);
      if (bus.req_i == 2'b11)   conflict_cnt_o <= sat_inc(conflict_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural
// single-port memory (combinational read, posedge write with byte/half/word
// enables) plus hand-written sequences for reset corner cases.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DMEM_ARB_PERF_EN
    .gnt_cnt0_o     (gnt_cnt0),
    .gnt_cnt1_o     (gnt_cnt1),
    .conflict_cnt_o (conflict_cnt),
`endif
    .bus            (bus)
  );

  // Memory model with a bench-side preload port used only while idle
  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else begin
      case (bus.mem_we_o)
        2'b01: mem[bus.mem_a_o[9:0]]       <= bus.mem_wd_o;
        2'b10: mem[bus.mem_a_o[9:0]][15:0] <= bus.mem_wd_o[15:0];
        2'b11: mem[bus.mem_a_o[9:0]][7:0]  <= bus.mem_wd_o[7:0];
        default: ;
      endcase
    end
  end
  assign bus.mem_rd_i = mem[bus.mem_a_o[9:0]];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we0;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [1:0]  we1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_a;
  } vec_t;

  vec_t tv[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic [1:0] req, logic [1:0] we0, logic [31:0] a0,
                              logic [31:0] wd0, logic [1:0] we1, logic [31:0] a1,
                              logic [31:0] wd1, logic [1:0] g, logic [1:0] rv,
                              logic [31:0] rd, logic [1:0] mwe, logic [31:0] ma);
    vec_t v;
    v.req = req; v.we0 = we0; v.a0 = a0; v.wd0 = wd0;
    v.we1 = we1; v.a1 = a1; v.wd1 = wd1;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.mem_we = mwe; v.mem_a = ma;
    return v;
  endfunction

  function automatic vec_t idle(logic [1:0] rv, logic [31:0] rd, logic [31:0] ma);
    return mk(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, rv, rd, 2'b00, ma);
  endfunction

  // Preloaded contents: word 0 holds 0x1234, words 1..7 hold 0xA000_000k
  function automatic logic [31:0] memv(int k);
    return (k == 0) ? 32'h0000_1234 : 32'hA000_0000 + 32'(k);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.req_i    = v.req;
    bus.we0_i    = v.we0;
    bus.addr0_i  = v.a0;
    bus.wdata0_i = v.wd0;
    bus.we1_i    = v.we1;
    bus.addr1_i  = v.a1;
    bus.wdata1_i = v.wd1;
  endtask

  task automatic preload(int a, logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_a = 10'(a); pre_d = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  initial begin
    // Conflict 11 x4 after reset: 01,10,01,10
    tv.push_back(mk(2'b11, 2'b00, 32'd1, 32'h0, 2'b00, 32'd2, 32'h0, 2'b01, 2'b00, 32'h0, 2'b00, 32'h0));
    tv.push_back(mk(2'b11, 2'b00, 32'd1, 32'h0, 2'b00, 32'd2, 32'h0, 2'b10, 2'b00, 32'h0, 2'b00, 32'd1));
    tv.push_back(mk(2'b11, 2'b00, 32'd1, 32'h0, 2'b00, 32'd2, 32'h0, 2'b01, 2'b01, memv(1), 2'b00, 32'd2));
    tv.push_back(mk(2'b11, 2'b00, 32'd1, 32'h0, 2'b00, 32'd2, 32'h0, 2'b10, 2'b10, memv(2), 2'b00, 32'd1));
    tv.push_back(idle(2'b01, memv(1), 32'd2));
    tv.push_back(idle(2'b10, memv(2), 32'd2));
    // Single read of 0x10000 by port 0
    tv.push_back(mk(2'b01, 2'b00, 32'h1_0000, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 2'b00, 32'd2));
    tv.push_back(idle(2'b00, 32'h0, 32'h1_0000));
    tv.push_back(idle(2'b01, 32'h0000_1234, 32'h1_0000));
    // Port 1 byte write to 290, port 0 reads 290 next cycle
    tv.push_back(mk(2'b10, 2'b00, 32'h0, 32'h0, 2'b11, 32'd290, 32'hDEAD_BEAB, 2'b10, 2'b00, 32'h0, 2'b00, 32'h1_0000));
    tv.push_back(mk(2'b01, 2'b00, 32'd290, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 2'b11, 32'd290));
    tv.push_back(idle(2'b10, 32'h0, 32'd290));
    tv.push_back(idle(2'b01, 32'h1122_33AB, 32'd290));
    // Back-to-back reads of 0..7 by port 0
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(2'b01, 2'b00, 32'(k), 32'h0, 2'b00, 32'h0, 32'h0, 2'b01,
                      (k >= 2) ? 2'b01 : 2'b00, (k >= 2) ? memv(k - 2) : 32'h0,
                      2'b00, (k == 0) ? 32'd290 : 32'(k - 1)));
    tv.push_back(idle(2'b01, memv(6), 32'd7));
    tv.push_back(idle(2'b01, memv(7), 32'd7));
    tv.push_back(idle(2'b00, 32'h0, 32'd7));
    // Half write, word write, then read both back
    tv.push_back(mk(2'b01, 2'b10, 32'd5, 32'h5555_CAFE, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 2'b00, 32'd7));
    tv.push_back(mk(2'b10, 2'b00, 32'h0, 32'h0, 2'b01, 32'd6, 32'h1234_5678, 2'b10, 2'b00, 32'h0, 2'b10, 32'd5));
    tv.push_back(mk(2'b11, 2'b00, 32'd5, 32'h0, 2'b00, 32'd6, 32'h0, 2'b01, 2'b01, 32'h0, 2'b01, 32'd6));
    tv.push_back(mk(2'b10, 2'b00, 32'h0, 32'h0, 2'b00, 32'd6, 32'h0, 2'b10, 2'b10, 32'h0, 2'b00, 32'd5));
    tv.push_back(idle(2'b01, 32'hA000_CAFE, 32'd6));
    tv.push_back(idle(2'b10, 32'h1234_5678, 32'd6));

    // Reset held with both ports requesting; preload memory meanwhile
    drive(mk(2'b11, 2'b01, 32'd3, 32'h5, 2'b01, 32'd4, 32'h6, 2'b00, 2'b00, 32'h0, 2'b00, 32'h0));
    for (int k = 0; k < 8; k++) preload(k, memv(k));
    preload(290, 32'h1122_3344);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_mem_a", bus.mem_a_o, 32'h0);
    chk("rst_mem_wd", bus.mem_wd_o, 32'h0);
    drive(idle(2'b00, 32'h0, 32'h0));
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      drive(tv[i]);
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i), 32'(bus.gnt_o), 32'(tv[i].gnt));
      chk($sformatf("row%0d_rvalid", i), 32'(bus.rvalid_o), 32'(tv[i].rvalid));
      chk($sformatf("row%0d_rdata", i), bus.rdata_o, tv[i].rdata);
      chk($sformatf("row%0d_mem_we", i), 32'(bus.mem_we_o), 32'(tv[i].mem_we));
      chk($sformatf("row%0d_mem_a", i), bus.mem_a_o, tv[i].mem_a);
    end

    // Reset mid-flight: word write granted in T, reset drops during T+1
    @(posedge clk); #1;
    drive(mk(2'b01, 2'b01, 32'd3, 32'hBADB_AD00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 2'b00, 32'h0));
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt_o), 32'h1);
    @(posedge clk); #1;
    drive(idle(2'b00, 32'h0, 32'h0));
    chk("mid_mem_we_before", 32'(bus.mem_we_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_we_rst", 32'(bus.mem_we_o), 32'h0);
    chk("mid_rvalid_rst", 32'(bus.rvalid_o), 32'h0);
    @(negedge clk);
    chk("mid_rvalid_t2", 32'(bus.rvalid_o), 32'h0);
    chk("mid_mem_unchanged", mem[3], memv(3));
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(mk(2'b11, 2'b00, 32'd3, 32'h0, 2'b00, 32'd4, 32'h0, 2'b00, 2'b00, 32'h0, 2'b00, 32'h0));
    @(negedge clk);
    chk("post_rst_conflict_gnt", 32'(bus.gnt_o), 32'h1);
    @(posedge clk); #1;
    drive(mk(2'b10, 2'b00, 32'h0, 32'h0, 2'b00, 32'd4, 32'h0, 2'b00, 2'b00, 32'h0, 2'b00, 32'h0));
    @(negedge clk);
    chk("post_rst_p1_gnt", 32'(bus.gnt_o), 32'h2);
    @(posedge clk); #1;
    drive(idle(2'b00, 32'h0, 32'h0));
    @(negedge clk);
    chk("post_rst_rv0", 32'(bus.rvalid_o), 32'h1);
    chk("post_rst_rd0", bus.rdata_o, memv(3));
    @(negedge clk);
    chk("post_rst_rv1", 32'(bus.rvalid_o), 32'h2);
    chk("post_rst_rd1", bus.rdata_o, memv(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
